// File: rtl/unsigned_mul_8x8_ha_array_seq_pkg.sv
// Shared types and constants for the 8x8 ha_array product sequencer.
// Row geometry of the external approximate half-adder array.
package unsigned_mul_8x8_ha_array_seq_pkg;

  localparam int W            = 8;
  localparam int ROWS         = 4;
  localparam int PW           = 16;
  localparam int B_W          = 7;
  localparam int T_W          = 9;
  localparam int B_WEIGHT_OFS = 2;
  localparam int ROW_SHIFT    = 2;
  localparam int RV_W         = T_W + 1;
  localparam int ADD_W        = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_array_seq_ha_row_fold.sv
// Folds one ha_array row pair (b, t) into its weighted 17-bit addend.
// b carries two extra bits of weight relative to t.
module unsigned_mul_8x8_ha_array_seq_ha_row_fold
  import unsigned_mul_8x8_ha_array_seq_pkg::*;
(
  input  logic [B_W-1:0]   b,
  input  logic [T_W-1:0]   t,
  input  logic [1:0]       row_idx,
  output logic [ADD_W-1:0] addend
);

  logic [RV_W-1:0] rowval;

  always_comb begin
    rowval = RV_W'(t) + (RV_W'(b) << B_WEIGHT_OFS);
    addend = ADD_W'(rowval) << (ROW_SHIFT * int'(row_idx));
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_seq.sv
// Sequencer: latches an operand pair, accumulates the four ha_array
// rows one per cycle through a shared adder, then hands off the product.
module unsigned_mul_8x8_ha_array_seq
  import unsigned_mul_8x8_ha_array_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [W-1:0]   arr_x,
  output logic [W-1:0]   arr_y,
  input  logic [B_W-1:0] ha_array_0_b,
  input  logic [T_W-1:0] ha_array_0_t,
  input  logic [B_W-1:0] ha_array_1_b,
  input  logic [T_W-1:0] ha_array_1_t,
  input  logic [B_W-1:0] ha_array_2_b,
  input  logic [T_W-1:0] ha_array_2_t,
  input  logic [B_W-1:0] ha_array_3_b,
  input  logic [T_W-1:0] ha_array_3_t,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  p,
  output logic           ovf
);

  state_t           state, state_d;
  logic [1:0]       row_idx;
  logic [PW-1:0]    acc;
  logic [B_W-1:0]   sel_b;
  logic [T_W-1:0]   sel_t;
  logic [ADD_W-1:0] addend;
  logic [ADD_W-1:0] sum;

  always_comb begin
    sel_b = ha_array_0_b;
    sel_t = ha_array_0_t;
    unique case (row_idx)
      2'd0: begin
        sel_b = ha_array_0_b;
        sel_t = ha_array_0_t;
      end
      2'd1: begin
        sel_b = ha_array_1_b;
        sel_t = ha_array_1_t;
      end
      2'd2: begin
        sel_b = ha_array_2_b;
        sel_t = ha_array_2_t;
      end
      2'd3: begin
        sel_b = ha_array_3_b;
        sel_t = ha_array_3_t;
      end
      default: ;
    endcase
  end

  unsigned_mul_8x8_ha_array_seq_ha_row_fold u_fold (
    .b       (sel_b),
    .t       (sel_t),
    .row_idx (row_idx),
    .addend  (addend)
  );

  // bit PW of the sum is the wrap-around carry for the sticky flag
  assign sum = {1'b0, acc} + addend;

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACC;
      end
      ACC: begin
        if (row_idx == 2'(ROWS - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      arr_x   <= '0;
      arr_y   <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        arr_x   <= x;
        arr_y   <= y;
        acc     <= '0;
        ovf     <= 1'b0;
        row_idx <= '0;
      end else if (state == ACC) begin
        acc     <= sum[PW-1:0];
        ovf     <= ovf | sum[PW];
        row_idx <= row_idx + 2'd1;
      end
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_seq.sv
// Self-checking bench for the ha_array product sequencer.
// The array is stubbed: exact x*y row digits, or forced row values.
module tb_unsigned_mul_8x8_ha_array_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x, y;
  logic [7:0]  arr_x, arr_y;
  logic [6:0]  hb [4];
  logic [8:0]  ht [4];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        ovf;

  logic             stub_exact;
  logic [3:0][9:0]  cur_rv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_array_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x            (x),
    .y            (y),
    .arr_x        (arr_x),
    .arr_y        (arr_y),
    .ha_array_0_b (hb[0]),
    .ha_array_0_t (ht[0]),
    .ha_array_1_b (hb[1]),
    .ha_array_1_t (ht[1]),
    .ha_array_2_b (hb[2]),
    .ha_array_2_t (ht[2]),
    .ha_array_3_b (hb[3]),
    .ha_array_3_t (ht[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .p            (p),
    .ovf          (ovf)
  );

  typedef struct {
    logic [7:0]      x;
    logic [7:0]      y;
    logic            exact;
    logic [3:0][9:0] rv;
    logic [15:0]     ep;
    logic            eovf;
  } vec_t;

  vec_t tbl [14];

  // Encode a row value v (<= 1019) as t + 4*b with b<=127, t<=511.
  function automatic logic [15:0] enc(input int v);
    int bb;
    int tt;
    bb = v >> 2;
    if (bb > 127) bb = 127;
    tt = v - 4 * bb;
    return {bb[6:0], tt[8:0]};
  endfunction

  always_comb begin
    int v;
    logic [15:0] e;
    v = 0;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      if (stub_exact) v = int'(arr_x) * int'((arr_y >> (2 * k)) & 8'd3);
      else            v = int'(cur_rv[k]);
      e = enc(v);
      hb[k] = e[15:9];
      ht[k] = e[8:0];
    end
  end

  // Reference: sum of row values weighted by 4^k, wrapped to 16 bits.
  function automatic logic [16:0] model(input logic [3:0][9:0] rv);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(rv[k]) * (1 << (2 * k));
    return {(s >= 65536), 16'(s % 65536)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int stall, input string nm);
    int lat;
    logic [15:0] hp;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 32'(in_ready), 1);
    x = v.x;
    y = v.y;
    stub_exact = v.exact;
    cur_rv = v.rv;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        chk({nm, " in_ready busy"}, 32'(in_ready), 0);
        x = ~v.x;
        y = 8'($urandom);
      end
      if (lat == 3) begin
        chk({nm, " arr_x"}, 32'(arr_x), 32'(v.x));
        chk({nm, " arr_y"}, 32'(arr_y), 32'(v.y));
      end
    end while (!out_valid && lat < 20);
    chk({nm, " latency"}, lat, 5);
    chk({nm, " p"}, 32'(p), 32'(v.ep));
    chk({nm, " ovf"}, 32'(ovf), 32'(v.eovf));
    hp = p;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, " stall out_valid"}, 32'(out_valid), 1);
      chk({nm, " stall p"}, 32'(p), 32'(hp));
      chk({nm, " stall in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " back idle"}, 32'(in_ready), 1);
    chk({nm, " out_valid drop"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic [16:0] m;
    logic [15:0] q [$];
    logic [15:0] got;
    logic [7:0]  px [3];
    logic [7:0]  py [3];
    int acc_cyc [3];
    int out_cyc [3];
    int idx, nout, cyc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    stub_exact = 1'b1;
    cur_rv = '0;

    tbl[0] = '{8'd1, 8'd1, 1'b1, '0, 16'd1, 1'b0};
    tbl[1] = '{8'd255, 8'd255, 1'b0,
               {10'd765, 10'd763, 10'd745, 10'd659}, 16'd64807, 1'b0};
    tbl[2] = '{8'd0, 8'd0, 1'b0,
               {10'd1019, 10'd1019, 10'd1019, 10'd1019}, 16'd21079, 1'b1};
    tbl[3] = '{8'd3, 8'd5, 1'b1, '0, 16'd15, 1'b0};
    tbl[4] = '{8'd200, 8'd123, 1'b1, '0, 16'd24600, 1'b0};
    for (int i = 5; i < 14; i++) begin
      tbl[i].x = 8'($urandom);
      tbl[i].y = 8'($urandom);
      tbl[i].exact = (i < 8);
      for (int k = 0; k < 4; k++)
        tbl[i].rv[k] = 10'($urandom_range(1019, 0));
      if (tbl[i].exact) begin
        tbl[i].ep = 16'(int'(tbl[i].x) * int'(tbl[i].y));
        tbl[i].eovf = 1'b0;
      end else begin
        m = model(tbl[i].rv);
        tbl[i].ep = m[15:0];
        tbl[i].eovf = m[16];
      end
    end

    #12;
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset p", 32'(p), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset arr_x", 32'(arr_x), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i], 0, $sformatf("vec%0d", i));

    run_op(tbl[1], 10, "stall");

    // abort mid-accumulation
    @(negedge clk);
    stub_exact = 1'b0;
    cur_rv = {10'd1019, 10'd1019, 10'd1019, 10'd1019};
    x = 8'hAA;
    y = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort p", 32'(p), 0);
    chk("abort ovf", 32'(ovf), 0);
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort in_ready", 32'(in_ready), 1);
    chk("abort arr_x", 32'(arr_x), 0);
    chk("abort arr_y", 32'(arr_y), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort no out_valid", 32'(out_valid), 0);
    end
    run_op(tbl[3], 0, "after abort");

    // back-to-back with in_valid held high
    stub_exact = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      px[i] = 8'($urandom);
      py[i] = 8'($urandom);
    end
    idx = 0;
    nout = 0;
    cyc = 0;
    while (nout < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        got = q.size() > 0 ? q.pop_front() : 16'hxxxx;
        chk($sformatf("b2b p%0d", nout), 32'(p), 32'(got));
        out_cyc[nout] = cyc;
        nout++;
      end
      if (in_ready && idx < 3) begin
        x = px[idx];
        y = py[idx];
        in_valid = 1'b1;
        q.push_back(16'(int'(px[idx]) * int'(py[idx])));
        acc_cyc[idx] = cyc;
        idx++;
      end else if (idx == 3) begin
        in_valid = 1'b0;
      end
    end
    chk("b2b results", nout, 3);
    if (nout == 3) begin
      chk("b2b first latency", out_cyc[0] - acc_cyc[0], 5);
      chk("b2b accept gap1", acc_cyc[1] - acc_cyc[0], 6);
      chk("b2b accept gap2", acc_cyc[2] - acc_cyc[1], 6);
      chk("b2b out gap1", out_cyc[1] - out_cyc[0], 6);
      chk("b2b out gap2", out_cyc[2] - out_cyc[1], 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_array_seq.md
Name: unsigned_mul_8x8_ha_array_seq

Overview:
- Sequencer for the unsigned 8x8 approximate half-adder partial-product array.
- Accepts one operand pair through a valid/ready handshake and registers it.
- Drives the registered operands into an externally instantiated ha_array stage, then folds the four row pairs into a 16-bit product, one row per cycle, using a single shared adder.
- Presents the result through a valid/ready output handshake; sits between the operand source and the product consumer.

Parameters:
- W, 8, operand width; fixed at 8 for the current ha_array.
- ROWS, 4, number of ha_array row pairs (W/2).
- PW, 16, product/accumulator width (2*W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- x  in  8  multiplicand
- y  in  8  multiplier
- arr_x  out  8  registered x to the ha_array
- arr_y  out  8  registered y to the ha_array
- ha_array_k_b  in  7  row k carry vector, k=0..3 (four ports)
- ha_array_k_t  in  9  row k sum vector, k=0..3 (four ports)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  16  product, mod 2^16
- ovf  out  1  accumulation wrapped past 2^16

Behaviour:
- Reset values (async on rst=1; all state clears immediately):
  - state=IDLE, row_idx=0, acc=0, ovf=0, arr_x=0, arr_y=0
  - in_ready=1, out_valid=0, p=0
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x into arr_x and y into arr_y, clear acc, ovf and row_idx, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle, the ha_array inputs for row_idx are sampled combinationally.
  - rowval(10b) = t_k + (b_k << 2); t[i] has weight i, b[i] has weight i+2.
  - Update: {carry, acc} = acc + (rowval << 2*row_idx). ovf is sticky-ORed with carry.
  - row_idx increments each cycle; after row 3, go to DONE.
  - Rows are always summed in order 0, 1, 2, 3.
- DONE:
  - out_valid=1; p=acc and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE.
  - in_ready remains 0 during DONE, so there is no same-cycle re-accept.
- Latency and throughput:
  - Accept at cycle 0; ACC occupies cycles 1–4; out_valid rises at cycle 5.
  - Minimum initiation interval is 6 cycles.
- Width rules:
  - All additions are unsigned.
  - rowval is zero-extended to 17 bits before the shift.
  - p is acc[15:0]; overflow bits are discarded and only flagged via ovf.
- Boundary behaviour:
  - x or y changing while not in IDLE is ignored.
  - in_valid held high through DONE is accepted on the first IDLE cycle after the handshake.
  - rst asserted mid-ACC or mid-DONE aborts the operation; no out_valid pulse is produced.
  - ha_array inputs are don't-care outside ACC.

Decomposition:
- Shared package contents:
  - state enum {IDLE, ACC, DONE}
  - constants W=8, ROWS=4, PW=16
  - B_W=7, T_W=9, B_WEIGHT_OFS=2, ROW_SHIFT=2
- One natural sub-module: ha_row_fold, a combinational block that turns (b, t, row_idx) into the shifted 17-bit addend.
- The FSM, counter and accumulator stay in the top module.
- The ha_array itself is instantiated by the parent, not inside this block.

Test Plan:
- x=1, y=1, with the real ha_array attached → out_valid at cycle 5, p=1, ovf=0.
- x=255, y=255, with the real ha_array attached → rowvals 659/745/763/765, p=64807, ovf=0.
- Stubbed array with all t=511 and all b=127 → each rowval=1019, sum 86615, p=21079, ovf=1.
- out_ready held 0 for 10 cycles in DONE → p and out_valid stable, in_ready=0; one cycle after out_ready=1, back in IDLE with in_ready=1.
- rst pulsed at cycle 3 of ACC → all outputs return to reset values immediately; a new pair x=3, y=5 completes normally with p=15.
- in_valid held high with 3 back-to-back pairs and out_ready=1 → three results, each 6 cycles apart, in input order.
